hazard_stall_controller: RTL and testbench

//  Pipeline hazard/stall sequencer for the 5-stage MIPS core. Detects load-use

---
 rtl/hazard_stall_controller.sv | 145 ++++++++++++++
 tb/tb_hazard_stall_controller.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// Load-use stall, branch flush and HALT sequencer for the 5-stage MIPS pipeline.
// Define STALL_COUNT_EN to add the o_bubble_count port and its bubble counter.
module hazard_stall_controller #(
    parameter int unsigned REG_ADDR_W   = 5,
    parameter int unsigned STALL_CYCLES = 1,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic [REG_ADDR_W-1:0] i_id_rs,
    input  logic [REG_ADDR_W-1:0] i_id_rt,
    input  logic                  i_id_uses_rt,
    input  logic [REG_ADDR_W-1:0] i_ex_rt,
    input  logic                  i_ex_mem_read,
    input  logic                  i_branch_taken,
    input  logic                  i_halt,
    output logic                  o_burbuja,
    output logic                  o_pc_write,
    output logic                  o_ifid_write,
    output logic                  o_ifid_flush,
`ifdef STALL_COUNT_EN
    output logic                  o_halted,
    output logic [CNT_W-1:0]      o_bubble_count
`else
    output logic                  o_halted
`endif
);

    localparam int unsigned StallW = $clog2(STALL_CYCLES + 1);
    localparam logic [StallW-1:0] StallInit = StallW'(STALL_CYCLES - 1);

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StStall = 2'd1,
        StHalt  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [StallW-1:0] stall_cnt_q, stall_cnt_d;
    logic              halted_q, halted_d;
    logic              load_use;

    assign load_use = i_ex_mem_read && (i_ex_rt != '0) &&
                      ((i_ex_rt == i_id_rs) || (i_id_uses_rt && (i_ex_rt == i_id_rt)));

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= StRun;
            stall_cnt_q <= '0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            halted_q    <= halted_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        halted_d    = halted_q;
        if (i_enable) begin
            unique case (state_q)
                StRun: begin
                    if (i_halt) begin
                        state_d  = StHalt;
                        halted_d = 1'b1;
                    end else if (load_use && (STALL_CYCLES > 1)) begin
                        // First bubble is issued from RUN; STALL covers the rest.
                        state_d     = StStall;
                        stall_cnt_d = StallInit;
                    end
                end
                StStall: begin
                    if (stall_cnt_q == StallW'(1)) begin
                        state_d     = StRun;
                        stall_cnt_d = '0;
                    end else begin
                        stall_cnt_d = stall_cnt_q - StallW'(1);
                    end
                end
                StHalt: begin
                    state_d = StHalt;
                end
                default: begin
                    state_d     = StRun;
                    stall_cnt_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        o_burbuja    = 1'b0;
        o_pc_write   = 1'b1;
        o_ifid_write = 1'b1;
        o_ifid_flush = 1'b0;
        if (i_reset) begin
            o_burbuja    = 1'b1;
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
        end else if (!i_enable) begin
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (i_halt || load_use) begin
                        o_burbuja    = 1'b1;
                        o_pc_write   = 1'b0;
                        o_ifid_write = 1'b0;
                    end else if (i_branch_taken) begin
                        o_ifid_flush = 1'b1;
                    end
                end
                default: begin
                    o_burbuja    = 1'b1;
                    o_pc_write   = 1'b0;
                    o_ifid_write = 1'b0;
                end
            endcase
        end
    end

    assign o_halted = halted_q;

`ifdef STALL_COUNT_EN
    logic [CNT_W-1:0] bubble_cnt_q;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            bubble_cnt_q <= '0;
        end else if (i_enable && o_burbuja && (state_q != StHalt)) begin
            bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
        end
    end

    assign o_bubble_count = bubble_cnt_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench: two controllers (1 and 3 stall cycles) against a cycle-level reference model.
module tb_hazard_stall_controller;

    logic       clk;
    logic       rst, en, uses_rt, mem_read, br, hlt;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       b1, pc1, ifw1, fl1, h1;
    logic       b3, pc3, ifw3, fl3, h3;
    logic [31:0] cnt1;
    logic [3:0]  cnt3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    hazard_stall_controller #(.REG_ADDR_W(5), .STALL_CYCLES(1), .CNT_W(32)) dut1 (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_id_rs(id_rs), .i_id_rt(id_rt),
        .i_id_uses_rt(uses_rt), .i_ex_rt(ex_rt), .i_ex_mem_read(mem_read),
        .i_branch_taken(br), .i_halt(hlt), .o_burbuja(b1), .o_pc_write(pc1),
        .o_ifid_write(ifw1), .o_ifid_flush(fl1),
`ifdef STALL_COUNT_EN
        .o_bubble_count(cnt1),
`endif
        .o_halted(h1)
    );

    hazard_stall_controller #(.REG_ADDR_W(5), .STALL_CYCLES(3), .CNT_W(4)) dut3 (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_id_rs(id_rs), .i_id_rt(id_rt),
        .i_id_uses_rt(uses_rt), .i_ex_rt(ex_rt), .i_ex_mem_read(mem_read),
        .i_branch_taken(br), .i_halt(hlt), .o_burbuja(b3), .o_pc_write(pc3),
        .o_ifid_write(ifw3), .o_ifid_flush(fl3),
`ifdef STALL_COUNT_EN
        .o_bubble_count(cnt3),
`endif
        .o_halted(h3)
    );

`ifndef STALL_COUNT_EN
    assign cnt1 = '0;
    assign cnt3 = '0;
`endif

    // {burbuja, pc_write, ifid_write, flush, halted} per instance plus bubble counts
    typedef struct packed {
        logic [4:0]  c1;
        logic [4:0]  c3;
        logic [31:0] n1;
        logic [3:0]  n3;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;

    // Reference model state, index 0 -> 1 stall cycle, index 1 -> 3 stall cycles
    int          stall_len[2] = '{1, 3};
    int          owed[2];
    bit          parked[2];
    int unsigned nbub[2];
    int unsigned cnt_mod[2] = '{0, 16};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [4:0] model_cycle(input int d, input bit lu);
        logic [4:0] o;
        bit bump;
        bump = 1'b0;
        if (rst) begin
            o = 5'b10000 | 5'(parked[d]);
            owed[d]   = 0;
            parked[d] = 1'b0;
            nbub[d]   = 0;
            return o;
        end
        if (!en)            o = 5'b00000;
        else if (parked[d]) o = 5'b10000;
        else if (owed[d] > 0) begin
            o = 5'b10000; owed[d]--; bump = 1'b1;
        end else if (hlt) begin
            o = 5'b10000; bump = 1'b1;
        end else if (lu) begin
            o = 5'b10000; owed[d] = stall_len[d] - 1; bump = 1'b1;
        end else if (br) o = 5'b01110;
        else             o = 5'b01100;
        o = o | 5'(parked[d]);
        if (en && !parked[d] && owed[d] == 0 && hlt && !(o[4] && bump && owed[d] != 0))
            parked[d] = parked[d] | (o == 5'b10000 && hlt && bump && !lu_pending(d));
        if (bump) begin
            nbub[d] = nbub[d] + 1;
            if (cnt_mod[d] != 0) nbub[d] = nbub[d] % cnt_mod[d];
        end
        return o;
    endfunction

    // Halt only takes effect when it was the accepted RUN-state decision.
    bit halt_taken[2];
    function automatic bit lu_pending(input int d);
        return !halt_taken[d];
    endfunction

    task automatic step(input bit r, input bit e, input logic [4:0] rs, input logic [4:0] rt,
                        input bit ur, input logic [4:0] ert, input bit mr, input bit b,
                        input bit h);
        exp_t x;
        bit   lu;
        @(posedge clk);
        #1;
        rst = r; en = e; id_rs = rs; id_rt = rt; uses_rt = ur; ex_rt = ert;
        mem_read = mr; br = b; hlt = h;
        lu = mr && (ert != 0) && ((ert == rs) || (ur && (ert == rt)));
        for (int d = 0; d < 2; d++) begin
            halt_taken[d] = !r && e && !parked[d] && owed[d] == 0 && h;
        end
        x.c1 = model_cycle(0, lu);
        x.c3 = model_cycle(1, lu);
        x.n1 = nbub[0];
        x.n3 = 4'(nbub[1]);
        sb.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 5'd1, 5'd2, 1, 5'd3, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("dut1 ctl", 32'({b1, pc1, ifw1, fl1, h1}), 32'(e.c1));
            check("dut3 ctl", 32'({b3, pc3, ifw3, fl3, h3}), 32'(e.c3));
`ifdef STALL_COUNT_EN
            check("dut1 bubble_count", cnt1, e.n1);
            check("dut3 bubble_count", 32'(cnt3), 32'(e.n3));
`endif
        end
    end

    initial begin
        rst = 1; en = 1; id_rs = 0; id_rt = 0; uses_rt = 0; ex_rt = 0;
        mem_read = 0; br = 0; hlt = 0;
        for (int d = 0; d < 2; d++) begin
            owed[d] = 0; parked[d] = 0; nbub[d] = 0; halt_taken[d] = 0;
        end
        repeat (3) step(1, 1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
        idle(2);
        step(0, 1, 5'd8, 5'd2, 0, 5'd8, 1, 0, 0);   // load-use on rs
        idle(4);
        step(0, 1, 5'd0, 5'd0, 1, 5'd0, 1, 0, 0);   // ex_rt = 0: no hazard
        step(0, 1, 5'd4, 5'd9, 0, 5'd9, 1, 0, 0);   // rt match but rt unused
        step(0, 1, 5'd4, 5'd9, 1, 5'd9, 1, 0, 0);   // rt match, rt used
        idle(3);
        step(0, 1, 5'd5, 5'd0, 0, 5'd5, 1, 1, 0);   // load-use beats branch
        step(0, 1, 5'd1, 5'd2, 0, 5'd3, 0, 1, 0);   // branch held
        idle(3);
        step(0, 1, 5'd7, 5'd0, 0, 5'd7, 1, 0, 0);   // stall, then freeze mid-stall
        idle(1);
        repeat (2) step(0, 0, 5'd1, 5'd2, 0, 5'd3, 0, 0, 0);
        idle(3);
        step(0, 1, 5'd1, 5'd2, 0, 5'd3, 0, 1, 1);   // halt beats branch
        step(0, 1, 5'd6, 5'd0, 0, 5'd6, 1, 1, 0);
        idle(3);
        step(1, 1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
        idle(2);
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 90,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 3);
        end
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
